fcvt_int2fp_ctrl: RTL

FCVT_INT2FP_CTRL -- requirements
Module: fcvt_int2fp_ctrl

---
 rtl/fcvt_int2fp_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fcvt_int2fp_ctrl.sv
// rtl/fcvt_int2fp_ctrl.sv - two-stage int32/uint32 to IEEE-754 single converter with valid/ready handshake
// Define FCVT_INT2FP_RNE_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fcvt_int2fp_ctrl #(
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_src,
  input  logic             in_unsigned,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_inexact,
  output logic             busy
);

  logic             s1_valid, s1_sign, s1_zero;
  logic [30:0]      s1_frac;
  logic [4:0]       s1_idx;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid, s2_inexact;
  logic [31:0]      s2_result;
  logic [TAG_W-1:0] s2_tag;

  logic             neg_in;
  logic [31:0]      mag_in;
  logic [4:0]       idx_in;
  logic             accept, drain, s1_adv;

  logic [30:0]      norm;
  logic [7:0]       exp_base, exp_fin;
  logic             round_up;
  logic [23:0]      mant_sum;
  logic [31:0]      result_d;
  logic             inexact_d;

  assign drain    = s2_valid & out_ready;
  assign s1_adv   = s1_valid & (~s2_valid | out_ready);
  assign in_ready = (~s1_valid | s1_adv) & ~flush;
  assign accept   = in_valid & in_ready;

  assign neg_in = in_src[31] & ~in_unsigned;
  assign mag_in = neg_in ? (~in_src + 32'd1) : in_src;

  always_comb begin
    idx_in = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag_in[i]) idx_in = 5'(i);
    end
  end

  // Shifting by 31-idx pushes the leading one out of the 31-bit window,
  // leaving the fraction bits left-aligned at bit 30.
  assign norm     = s1_frac << ~s1_idx;
  assign exp_base = 8'd127 + {3'd0, s1_idx};

`ifdef FCVT_INT2FP_RNE_EN
  assign round_up = norm[7] & ((|norm[6:0]) | norm[8]);
`else
  assign round_up = 1'b0;
`endif

  // A carry out of the mantissa leaves mant_sum[22:0] all zero, as required.
  assign mant_sum  = {1'b0, norm[30:8]} + {23'd0, round_up};
  assign exp_fin   = exp_base + {7'd0, mant_sum[23]};
  assign result_d  = s1_zero ? 32'd0 : {s1_sign, exp_fin, mant_sum[22:0]};
  assign inexact_d = ~s1_zero & (|norm[7:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_frac  <= '0;
      s1_idx   <= '0;
      s1_tag   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_sign  <= neg_in;
      s1_zero  <= (mag_in == 32'd0);
      s1_frac  <= mag_in[30:0];
      s1_idx   <= idx_in;
      s1_tag   <= in_tag;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      s2_result  <= '0;
      s2_inexact <= 1'b0;
      s2_tag     <= '0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s1_adv) begin
      s2_valid   <= 1'b1;
      s2_result  <= result_d;
      s2_inexact <= inexact_d;
      s2_tag     <= s1_tag;
    end else if (drain) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_valid   = s2_valid;
  assign out_result  = s2_result;
  assign out_tag     = s2_tag;
  assign out_inexact = s2_inexact;
  assign busy        = s1_valid | s2_valid;

endmodule
